// File: rtl/wb_openram_multibank.sv
// ---------------------------------------------------------------------------
// wb_openram_multibank
//   Wishbone classic slave that maps an address window onto NUM_BANKS
//   OpenRAM single-port macros (port 0 RW). Every access is sequenced by a
//   registered IDLE -> ISSUE -> (WAIT) -> ACK state machine. In-window
//   addresses beyond the populated banks are acked with zero data and no
//   macro access.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i    Wishbone strobe, cycle, write enable
//   wbs_sel_i, wbs_dat_i    byte lanes and write data
//   wbs_adr_i               byte address
//   wbs_ack_o, wbs_dat_o    single-cycle ack, read data (zero outside ack)
//   ram_clk0                macro clock (wb_clk_i)
//   ram_csb0                per-bank chip select, active low
//   ram_web0, ram_wmask0    shared write enable (active low), byte mask
//   ram_addr0, ram_din0     shared word address and write data
//   ram_dout0               packed read data, bank k at [32k+31:32k]
// ---------------------------------------------------------------------------
module wb_openram_multibank #(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK       = 32'hFFFF_F000,
  parameter int          NUM_BANKS       = 2,
  parameter int          BANK_ADDR_WIDTH = 8,
  parameter int          READ_LATENCY    = 1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_dat_i,
  input  logic [31:0]                wbs_adr_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic                       ram_clk0,
  output logic [NUM_BANKS-1:0]       ram_csb0,
  output logic                       ram_web0,
  output logic [3:0]                 ram_wmask0,
  output logic [BANK_ADDR_WIDTH-1:0] ram_addr0,
  output logic [31:0]                ram_din0,
  input  logic [NUM_BANKS*32-1:0]    ram_dout0
);

  localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W = 2;  // holds READ_LATENCY-1 for latencies 1..4

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                     state_q, state_d;
  logic [NUM_BANKS-1:0]       csb_q, csb_d;
  logic                       web_q, web_d;
  logic [3:0]                 wmask_q, wmask_d;
  logic [BANK_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                din_q, din_d;
  logic                       ack_q, ack_d;
  logic [31:0]                dat_q, dat_d;
  logic [SEL_W-1:0]           bank_q, bank_d;
  logic                       we_q, we_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       abort_q, abort_d;

  // Address decode, only meaningful while IDLE.
  logic [31:0]      offset;
  logic [SEL_W-1:0] bank;
  logic             hit, bank_ok, req;
  logic [31:0]      rd_slice;

  assign offset   = (wbs_adr_i & ~ADDR_MASK) >> (BANK_ADDR_WIDTH + 2);
  assign bank     = offset[SEL_W-1:0];
  assign hit      = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  assign bank_ok  = offset < 32'(NUM_BANKS);
  assign req      = wbs_stb_i & wbs_cyc_i & hit;
  assign rd_slice = ram_dout0[32*int'(bank_q) +: 32];

  always_comb begin
    state_d = state_q;
    csb_d   = csb_q;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    bank_d  = bank_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    ack_d   = 1'b0;
    dat_d   = '0;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (req) begin
          if (bank_ok) begin
            csb_d       = '1;
            csb_d[bank] = 1'b0;
            web_d       = ~wbs_we_i;
            wmask_d     = wbs_we_i ? wbs_sel_i : 4'h0;
            addr_d      = wbs_adr_i[BANK_ADDR_WIDTH+1:2];
            din_d       = wbs_dat_i;
            bank_d      = bank;
            we_d        = wbs_we_i;
            state_d     = ISSUE;
          end else begin
            // Unpopulated bank: immediate zero-data ack, writes dropped.
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end
      end

      ISSUE: begin
        // The macro samples at the end of this cycle; release it afterwards.
        csb_d   = '1;
        web_d   = 1'b1;
        abort_d = abort_q | ~wbs_cyc_i;
        if (we_q) begin
          ack_d   = wbs_cyc_i & ~abort_q;
          state_d = ACK;
        end else begin
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = WAIT;
        end
      end

      WAIT: begin
        abort_d = abort_q | ~wbs_cyc_i;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // An abandoned cycle must not leak data onto wbs_dat_o.
          ack_d   = wbs_cyc_i & ~abort_q;
          dat_d   = ack_d ? rd_slice : 32'h0;
          state_d = ACK;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      csb_q   <= '1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      bank_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      bank_q  <= bank_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign ram_clk0   = wb_clk_i;
  assign ram_csb0   = csb_q;
  assign ram_web0   = web_q;
  assign ram_wmask0 = wmask_q;
  assign ram_addr0  = addr_q;
  assign ram_din0   = din_q;
  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_openram_multibank.sv
// ---------------------------------------------------------------------------
// tb_wb_openram_multibank
//   Two instances (READ_LATENCY 1 and 3) each backed by a behavioural SRAM
//   macro model. A word-level reference memory plus the window/bank rules
//   give the expected ack cycle, read data and macro pin values.
// ---------------------------------------------------------------------------
module tb_wb_openram_multibank;
  localparam int          NB   = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_F000;
  localparam int          BUD  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stb, cyc, we, use3, mem_clr;
  logic [3:0]  sel;
  logic [31:0] dat, adr;

  logic stb1, cyc1, stb3, cyc3;
  assign stb1 = stb & ~use3;
  assign cyc1 = cyc & ~use3;
  assign stb3 = stb & use3;
  assign cyc3 = cyc & use3;

  logic ack1, ack3, rclk1, rclk3, web1, web3;
  logic [31:0] dat1, dat3, din1, din3;
  logic [NB-1:0] csb1, csb3;
  logic [3:0] wm1, wm3;
  logic [7:0] a1, a3;
  logic [NB*32-1:0] dout1, dout3;

  wb_openram_multibank #(.READ_LATENCY(1)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb1), .wbs_cyc_i(cyc1),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(ack1), .wbs_dat_o(dat1), .ram_clk0(rclk1), .ram_csb0(csb1),
    .ram_web0(web1), .ram_wmask0(wm1), .ram_addr0(a1), .ram_din0(din1),
    .ram_dout0(dout1));

  wb_openram_multibank #(.READ_LATENCY(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb3), .wbs_cyc_i(cyc3),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(ack3), .wbs_dat_o(dat3), .ram_clk0(rclk3), .ram_csb0(csb3),
    .ram_web0(web3), .ram_wmask0(wm3), .ram_addr0(a3), .ram_din0(din3),
    .ram_dout0(dout3));

  // Observed view of whichever instance is currently selected.
  logic o_ack, o_web;
  logic [31:0] o_dat, o_din;
  logic [NB-1:0] o_csb;
  logic [3:0] o_wm;
  logic [7:0] o_a;
  assign o_ack = use3 ? ack3 : ack1;
  assign o_dat = use3 ? dat3 : dat1;
  assign o_csb = use3 ? csb3 : csb1;
  assign o_web = use3 ? web3 : web1;
  assign o_wm  = use3 ? wm3  : wm1;
  assign o_a   = use3 ? a3   : a1;
  assign o_din = use3 ? din3 : din1;

  // Macro models: sample on the rising edge while selected.
  logic [31:0] mem1 [NB*256];
  logic [31:0] mem3 [NB*256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < NB*256; i++) begin mem1[i] = '0; mem3[i] = '0; end
      dout1 <= '0;
      dout3 <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (!csb1[k]) begin
          if (!web1) begin
            for (int b = 0; b < 4; b++) if (wm1[b]) mem1[k*256+int'(a1)][8*b +: 8] = din1[8*b +: 8];
          end else dout1[32*k +: 32] <= mem1[k*256+int'(a1)];
        end
        if (!csb3[k]) begin
          if (!web3) begin
            for (int b = 0; b < 4; b++) if (wm3[b]) mem3[k*256+int'(a3)][8*b +: 8] = din3[8*b +: 8];
          end else dout3[32*k +: 32] <= mem3[k*256+int'(a3)];
        end
      end
    end
  end

  // Reference model: one flat word memory per instance.
  logic [31:0] ref_mem [2][NB*256];
  int nvec, nerr;

  function automatic logic hit_f(input logic [31:0] a);
    return (a & MASK) == BASE;
  endfunction
  function automatic int off_f(input logic [31:0] a);
    return int'((a & ~MASK) >> 10);
  endfunction

  // One Wishbone access. abort_at: cycle index at whose start cyc/stb drop.
  task automatic xfer(input string nm, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int abort_at, input bit scramble);
    int u = int'(use3);
    int rl = use3 ? 3 : 1;
    logic h = hit_f(a);
    int off = off_f(a);
    logic v = h && (off < NB);
    int idx = off*256 + int'(a[9:2]);
    int exp_t = !h ? -1 : (!v ? 1 : (w ? 2 : 2 + rl));
    logic [31:0] exp_d = 32'h0;
    logic [NB-1:0] exp_csb = '1;
    int ack_t = -1, nack = 0, bad_dat = 0, bad_csb = 0, bad_web = 0;
    logic [31:0] got_d = 32'h0, din_t1 = 32'h0;
    logic [NB-1:0] csb_t1 = '1;
    logic web_t1 = 1'b1;
    logic [3:0] wm_t1 = 4'h0;
    logic [7:0] a_t1 = 8'h0;
    if (v && !w) exp_d = ref_mem[u][idx];
    if (v) exp_csb[off] = 1'b0;
    if (abort_at >= 1 && abort_at < exp_t) exp_t = -1;

    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    for (int t = 0; t < BUD; t++) begin
      if (t == abort_at) begin stb = 1'b0; cyc = 1'b0; end
      if (scramble && h && t > 0) begin
        adr = $urandom; dat = $urandom; sel = 4'($urandom); we = 1'($urandom);
      end
      @(negedge clk);
      if (o_ack) begin
        nack++;
        if (ack_t < 0) begin ack_t = t; got_d = o_dat; end
      end else if (o_dat !== 32'h0) bad_dat++;
      if (t == 1) begin
        csb_t1 = o_csb; web_t1 = o_web; wm_t1 = o_wm; a_t1 = o_a; din_t1 = o_din;
      end else begin
        if (o_csb !== '1) bad_csb++;
        if (o_web !== 1'b1) bad_web++;
      end
      @(posedge clk); #1;
      if (ack_t >= 0) begin stb = 1'b0; cyc = 1'b0; end
    end
    stb = 1'b0; cyc = 1'b0;

    if (v && w)
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[u][idx][8*b +: 8] = d[8*b +: 8];

    nvec++;
    if (ack_t != exp_t || nack != ((exp_t < 0) ? 0 : 1)) begin
      nerr++;
      $display("FAIL %s ack: got cycle %0d count %0d, want cycle %0d", nm, ack_t, nack, exp_t);
    end
    if (exp_t >= 0) begin
      nvec++;
      if (got_d !== exp_d) begin
        nerr++;
        $display("FAIL %s dat_o: got %h want %h", nm, got_d, exp_d);
      end
    end
    nvec++;
    if (bad_dat != 0) begin
      nerr++;
      $display("FAIL %s dat_o outside ack: %0d nonzero cycles, want 0", nm, bad_dat);
    end
    nvec++;
    if (csb_t1 !== exp_csb || bad_csb != 0) begin
      nerr++;
      $display("FAIL %s csb0: T1 %b want %b, %0d other cycles not idle", nm, csb_t1, exp_csb, bad_csb);
    end
    nvec++;
    if (bad_web != 0 || (!v && web_t1 !== 1'b1)) begin
      nerr++;
      $display("FAIL %s web0: %0d bad cycles, T1 %b", nm, bad_web, web_t1);
    end
    if (v) begin
      nvec++;
      if (web_t1 !== ~w || wm_t1 !== (w ? s : 4'h0) || a_t1 !== a[9:2] || din_t1 !== d) begin
        nerr++;
        $display("FAIL %s T1 pins: web %b wmask %h addr %h din %h, want %b %h %h %h",
                 nm, web_t1, wm_t1, a_t1, din_t1, ~w, (w ? s : 4'h0), a[9:2], d);
      end
    end
  endtask

  task automatic check_reset_pins(input string nm);
    nvec++;
    if ({ack1, ack3} !== 2'b00 || dat1 !== 32'h0 || dat3 !== 32'h0 ||
        csb1 !== '1 || csb3 !== '1 || web1 !== 1'b1 || web3 !== 1'b1 ||
        wm1 !== 4'h0 || wm3 !== 4'h0 || a1 !== 8'h0 || a3 !== 8'h0 ||
        din1 !== 32'h0 || din3 !== 32'h0) begin
      nerr++;
      $display("FAIL %s: ack %b%b csb %b/%b web %b%b wmask %h/%h addr %h/%h din %h/%h dat %h/%h, want reset values",
               nm, ack1, ack3, csb1, csb3, web1, web3, wm1, wm3, a1, a3, din1, din3, dat1, dat3);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = 4'h0; dat = 32'h0; adr = 32'h0; use3 = 1'b0;
    for (int i = 0; i < NB*256; i++) begin ref_mem[0][i] = '0; ref_mem[1][i] = '0; end
    repeat (3) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    check_reset_pins("reset");
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    use3 = 1'b0;
    xfer("wr_404", 1'b1, 32'h3000_0404, 32'hDEAD_BEEF, 4'hF, -1, 0);
    xfer("rd_404", 1'b0, 32'h3000_0404, 32'h0, 4'hF, -1, 0);
    use3 = 1'b1;
    xfer("wr_404_rl3", 1'b1, 32'h3000_0404, 32'hCAFE_F00D, 4'hF, -1, 0);
    xfer("rd_404_rl3", 1'b0, 32'h3000_0404, 32'h0, 4'hF, -1, 0);
  endtask

  task automatic test_byte_lane();
    use3 = 1'b0;
    xfer("wr_008_full", 1'b1, 32'h3000_0008, 32'h1122_3344, 4'hF, -1, 0);
    xfer("wr_008_lane2", 1'b1, 32'h3000_0008, 32'h00AA_0000, 4'h4, -1, 0);
    xfer("rd_008", 1'b0, 32'h3000_0008, 32'h0, 4'hF, -1, 0);
  endtask

  task automatic test_invalid_bank();
    use3 = 1'b0;
    xfer("rd_800", 1'b0, 32'h3000_0800, 32'h0, 4'hF, -1, 0);
    xfer("wr_800", 1'b1, 32'h3000_0800, 32'h1234_5678, 4'hF, -1, 0);
    use3 = 1'b1;
    xfer("rd_C04_rl3", 1'b0, 32'h3000_0C04, 32'h0, 4'hF, -1, 0);
  endtask

  task automatic test_window_miss();
    use3 = 1'b0;
    xfer("rd_1000", 1'b0, 32'h3000_1000, 32'h0, 4'hF, -1, 0);
    xfer("wr_2FFFFFFC", 1'b1, 32'h2FFF_FFFC, 32'h5555_AAAA, 4'hF, -1, 0);
  endtask

  task automatic test_abort();
    use3 = 1'b1;
    xfer("wr_410_rl3", 1'b1, 32'h3000_0410, 32'h0BAD_CAFE, 4'hF, -1, 0);
    xfer("rd_410_abort_wait", 1'b0, 32'h3000_0410, 32'h0, 4'hF, 3, 0);
    xfer("rd_410_after_abort", 1'b0, 32'h3000_0410, 32'h0, 4'hF, -1, 0);
    use3 = 1'b0;
    xfer("wr_01C_abort_issue", 1'b1, 32'h3000_001C, 32'h7777_1111, 4'hF, 1, 0);
    xfer("rd_01C_committed", 1'b0, 32'h3000_001C, 32'h0, 4'hF, -1, 0);
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] csb_issue;
    use3 = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0404; sel = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    csb_issue = csb1;
    nvec++;
    if (csb_issue !== 2'b01) begin
      nerr++;
      $display("FAIL rst_mid issue csb0: got %b want 01", csb_issue);
    end
    @(negedge clk);
    check_reset_pins("rst_mid");
    @(posedge clk); #1 rst = 1'b0;
    xfer("rd_404_after_rst", 1'b0, 32'h3000_0404, 32'h0, 4'hF, -1, 0);
  endtask

  task automatic test_back_to_back();
    logic [8:0] ack_mask = '0, csb_mask = '0;
    use3 = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0420; dat = 32'h600D_D00D; sel = 4'hF;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      ack_mask[t] = o_ack;
      csb_mask[t] = (o_csb !== 2'b11);
      @(posedge clk); #1;
    end
    stb = 1'b0; cyc = 1'b0;
    ref_mem[0][32'h420 >> 2] = 32'h600D_D00D;
    nvec++;
    if (ack_mask !== 9'b100100100) begin
      nerr++;
      $display("FAIL b2b ack cycles: got %b want 100100100", ack_mask);
    end
    nvec++;
    if (csb_mask !== 9'b010010010) begin
      nerr++;
      $display("FAIL b2b csb cycles: got %b want 010010010", csb_mask);
    end
    repeat (2) @(posedge clk);
    #1;
    xfer("rd_420_b2b", 1'b0, 32'h3000_0420, 32'h0, 4'hF, -1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic w;
      int cls, ab;
      cls = $urandom_range(0, 9);
      w = 1'($urandom);
      ab = -1;
      use3 = 1'($urandom);
      if (cls < 7)
        a = BASE | (32'($urandom_range(0, NB-1)) << 10) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      else if (cls < 9)
        a = BASE | (32'($urandom_range(NB, 3)) << 10) | 32'($urandom_range(0, 1023));
      else begin
        a = $urandom;
        if (hit_f(a)) a = a ^ 32'h1000_0000;
      end
      if (cls < 7 && $urandom_range(0, 7) == 0)
        ab = w ? 1 : $urandom_range(1, 1 + (use3 ? 3 : 1));
      xfer("rand", w, a, $urandom, 4'($urandom), ab, 1);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    test_reset();
    test_basic();
    test_byte_lane();
    test_invalid_bank();
    test_window_miss();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/wb_openram_multibank.md
Name: wb_openram_multibank

Overview:
Wishbone classic slave that maps a configurable address window onto NUM_BANKS OpenRAM single-port macros. Each macro is sky130_sram_1kbyte_1rw1r_32x256_8-style, port 0 RW. It sits in user_project_wrapper between the Caravel WB MI A port and the SRAM instances. It decodes the bank, sequences the macro through a registered issue/wait/ack FSM with configurable read latency, and returns a zero-data ack for in-window addresses beyond the populated banks.

Parameters:
BASE_ADDR, 32'h3000_0000, window base; hit when (wbs_adr_i & ADDR_MASK) == BASE_ADDR
ADDR_MASK, 32'hFFFF_F000, window mask
NUM_BANKS, 2, number of macros, 1..8
BANK_ADDR_WIDTH, 8, word address width per macro (256 words x 32 bit)
READ_LATENCY, 1, cycles after the macro sampling edge before dout is captured, 1..4
Derived localparams: SEL_W = max(1, clog2(NUM_BANKS)); OFFSET = (wbs_adr_i & ~ADDR_MASK) >> (BANK_ADDR_WIDTH+2)

Ports:
wb_clk_i  in  1  clock; the only clock
wb_rst_i  in  1  reset, synchronous, active-high
wbs_stb_i  in  1  WB strobe
wbs_cyc_i  in  1  WB cycle
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  byte lane select
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  ack, single-cycle pulse
wbs_dat_o  out  32  read data
ram_clk0  out  1  macro clock, equal to wb_clk_i
ram_csb0  out  NUM_BANKS  per-bank chip select, active low
ram_web0  out  1  shared write enable, active low
ram_wmask0  out  4  shared byte write mask
ram_addr0  out  BANK_ADDR_WIDTH  shared word address
ram_din0  out  32  shared write data
ram_dout0  in  NUM_BANKS*32  packed read data; bank k occupies [32k+31:32k]

Behaviour:
- Clocking and reset: one clock wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values, also applied on reset mid-operation: state=IDLE, ram_csb0 all 1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0, wbs_ack_o=0, wbs_dat_o=0. An aborted access never acks.
- Address decode: word = wbs_adr_i[BANK_ADDR_WIDTH+1:2]. Bank = OFFSET[SEL_W-1:0]. Valid bank iff OFFSET < NUM_BANKS.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - stb&cyc with a window hit and valid bank: on the edge, register ram_csb0[bank]=0 (others 1), ram_web0=~we, ram_wmask0=we?sel:0, ram_addr0, ram_din0. Latch bank and we. Go to ISSUE.
  - stb&cyc with a window hit and invalid bank: go to ACK with no macro access. Read data is 0 and writes are dropped.
  - Window miss: stay in IDLE; never ack.
- ISSUE: this is the single cycle the macro samples. On exit, ram_csb0 goes all 1 and ram_web0 goes 1. A write goes to ACK. A read loads cnt=READ_LATENCY-1 and goes to WAIT.
- WAIT: while cnt!=0, decrement. When cnt==0, register ram_dout0 slice[bank] into the data register and go to ACK.
- ACK: wbs_ack_o=1 for exactly one cycle, qualified by wbs_cyc_i. wbs_dat_o = captured data on a read, 0 on a write or invalid bank. Next state is IDLE.
- wbs_dat_o is 0 in every non-ack cycle.
- Latency, with T0 the first cycle stb&cyc is seen in IDLE:
  - valid write: ack in T2
  - valid read: ack in T(2+READ_LATENCY)
  - invalid bank: ack in T1
- Back-to-back: IDLE samples stb&cyc in the cycle after ACK. A held stb starts a new access, giving a minimum spacing of 3 cycles for writes.
- Cycle abort: if cyc drops during ISSUE or WAIT, the macro access completes (a write is committed), the FSM runs to ACK, and the ack is suppressed.
- ram_csb0 is low for at most one bank and for at most one cycle per access.
- wbs_adr_i, wbs_dat_i, wbs_sel_i and wbs_we_i are sampled only in IDLE. Later changes are ignored until ACK.

Test Plan:
- Reset, then write 0x3000_0404 data 0xDEADBEEF sel 0xF -> in T1: ram_csb0=2'b01, web0=0, addr0=0x01, wmask0=0xF, din0=0xDEADBEEF; ack in T2 with dat_o=0.
- Read 0x3000_0404 with model bank1 word1=0xDEADBEEF, READ_LATENCY=1 -> csb0[1] low only in T1; ack in T3 with dat_o=0xDEADBEEF; dat_o=0 in T2 and T4.
- Write 0x3000_0008 sel 0x4 data 0x00AA0000 then read it back -> wmask0=0x4 on bank0 only; readback byte2=0xAA, other bytes unchanged.
- Access 0x3000_0800 (OFFSET=2 >= NUM_BANKS) read and write -> ack in T1, dat_o=0, ram_csb0 stays 2'b11 throughout.
- Access 0x3000_1000 (window miss) with stb held 10 cycles -> no ack, csb0 stays 2'b11.
- cyc dropped in WAIT (READ_LATENCY=3) -> no ack; FSM back in IDLE and the next read completes normally. wb_rst_i asserted in ISSUE -> csb0=2'b11 and state=IDLE on the next edge.
